// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: default bus widths, master indices and the
// request-arbiter state encoding.
package xbar_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/wr_req_if.sv
// Write-request bundle between a master switch and a slave port.
// The "out" side drives the request; the "in" side receives it.
interface wr_req_if #(
  parameter int ADDR_W = xbar_pkg::ADDR_W_DEF,
  parameter int DATA_W = xbar_pkg::DATA_W_DEF,
  parameter int SEL_W  = 1
);

  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              req;

  modport out (output sel, addr, wdata, req);
  modport in  (input  sel, addr, wdata, req);

endinterface

// File: rtl/rr_arb2.sv
// Two-way priority arbiter: a lone requester wins, and a tie goes to the
// master named by prio.
module rr_arb2
  import xbar_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       grant,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = |req;
    grant     = M0;
    case (req)
      2'b01:   grant = M0;
      2'b10:   grant = M1;
      2'b11:   grant = prio;
      default: grant = M0;
    endcase
  end

endmodule

// File: rtl/wr_req_arbiter.sv
// Slave-port write arbiter: picks one of two masters, holds its request to
// the slave until acknowledged, and routes the ack back to the owner.
module wr_req_arbiter
  import xbar_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  wr_req_if.in      i_wr_req_m0,
  wr_req_if.in      i_wr_req_m1,
  wr_req_if.out     o_wr_req_slv,
  input  logic      i_slv_ack,
  output logic      o_ack_m0,
  output logic      o_ack_m1
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q, prio_d;
  logic              armed_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              grant;
  logic              grant_vld;

  rr_arb2 u_arb (
    .req       ({i_wr_req_m1.req, i_wr_req_m0.req}),
    .prio      (prio_q),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // armed_q holds off granting on the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= M0;
      prio_q  <= M0;
      armed_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      armed_q <= 1'b1;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    o_ack_m0 = 1'b0;
    o_ack_m1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && grant_vld) begin
          state_d = BUSY;
          owner_d = grant;
          addr_d  = (grant == M1) ? i_wr_req_m1.addr  : i_wr_req_m0.addr;
          wdata_d = (grant == M1) ? i_wr_req_m1.wdata : i_wr_req_m0.wdata;
        end
      end
      BUSY: begin
        if (i_slv_ack) begin
          o_ack_m0 = (owner_q == M0);
          o_ack_m1 = (owner_q == M1);
          state_d  = IDLE;
          prio_d   = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side fields are forced to zero whenever no transaction is live.
  always_comb begin
    o_wr_req_slv.req   = (state_q == BUSY);
    o_wr_req_slv.sel   = (state_q == BUSY) ? SEL_W'(owner_q) : '0;
    o_wr_req_slv.addr  = (state_q == BUSY) ? addr_q  : '0;
    o_wr_req_slv.wdata = (state_q == BUSY) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_wr_req_arbiter.sv
// Directed bench for wr_req_arbiter: reset, single grant, contention,
// alternation, request hold-off, reset mid-transaction and idle acks.
module tb_wr_req_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic slv_ack;
  logic ack_m0, ack_m1;
  int   tests;
  int   fails;

  wr_req_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(1)) m0_if ();
  wr_req_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(1)) m1_if ();
  wr_req_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(1)) slv_if ();

  wr_req_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_req_m0  (m0_if),
    .i_wr_req_m1  (m1_if),
    .o_wr_req_slv (slv_if),
    .i_slv_ack    (slv_ack),
    .o_ack_m0     (ack_m0),
    .o_ack_m1     (ack_m1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_if.req = 1'b0; m0_if.sel = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.sel = 1'b1; m1_if.addr = '0; m1_if.wdata = '0;
    slv_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    tests++;
    if ({slv_if.req, slv_if.sel, ack_m0, ack_m1} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: req/sel/ack0/ack1=%b required 0000",
               {slv_if.req, slv_if.sel, ack_m0, ack_m1});
    end
    tests++;
    if (slv_if.addr !== 32'h0 || slv_if.wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h required 0/0", slv_if.addr, slv_if.wdata);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    rst_n = 1'b1;
    m0_if.req = 1'b1; m0_if.addr = 32'h10; m0_if.wdata = 32'hAA;
    tick();
    tests++;
    if (slv_if.req !== 1'b0) begin
      fails++;
      $display("FAIL first_edge_nogrant: req=%b required 0", slv_if.req);
    end
    tick();
    tests++;
    if (slv_if.req !== 1'b1 || slv_if.sel !== 1'b0 || slv_if.addr !== 32'h10 ||
        slv_if.wdata !== 32'hAA) begin
      fails++;
      $display("FAIL basic_grant: req=%b sel=%b addr=%h wdata=%h required 1 0 10 aa",
               slv_if.req, slv_if.sel, slv_if.addr, slv_if.wdata);
    end
    tests++;
    if (ack_m0 !== 1'b0 || ack_m1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_noack: ack0=%b ack1=%b required 0 0", ack_m0, ack_m1);
    end
    slv_ack = 1'b1;
    #1;
    tests++;
    if (ack_m0 !== 1'b1 || ack_m1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_ack: ack0=%b ack1=%b required 1 0", ack_m0, ack_m1);
    end
    tick();
    slv_ack = 1'b0;
    m0_if.req = 1'b0;
    #1;
    tests++;
    if (slv_if.req !== 1'b0 || slv_if.addr !== 32'h0) begin
      fails++;
      $display("FAIL basic_idle: req=%b addr=%h required 0 0", slv_if.req, slv_if.addr);
    end
  endtask

  task automatic test_contention();
    logic [1:0] order [3];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd0;
    do_reset();
    m0_if.req = 1'b1; m0_if.addr = 32'h100; m0_if.wdata = 32'h1;
    m1_if.req = 1'b1; m1_if.addr = 32'h200; m1_if.wdata = 32'h2;
    for (int t = 0; t < 3; t++) begin
      tick();
      tests++;
      if (slv_if.req !== 1'b1 || slv_if.sel !== order[t][0] ||
          slv_if.addr !== (order[t][0] ? 32'h200 : 32'h100)) begin
        fails++;
        $display("FAIL contention_grant[%0d]: req=%b sel=%b addr=%h required 1 %b %h",
                 t, slv_if.req, slv_if.sel, slv_if.addr, order[t][0],
                 order[t][0] ? 32'h200 : 32'h100);
      end
      slv_ack = 1'b1;
      #1;
      tests++;
      if (ack_m0 !== ~order[t][0] || ack_m1 !== order[t][0]) begin
        fails++;
        $display("FAIL contention_ack[%0d]: ack0=%b ack1=%b required %b %b",
                 t, ack_m0, ack_m1, ~order[t][0], order[t][0]);
      end
      tick();
      slv_ack = 1'b0;
      tests++;
      if (slv_if.req !== 1'b0) begin
        fails++;
        $display("FAIL contention_idle[%0d]: req=%b required 0", t, slv_if.req);
      end
      // m0 finished its first write; both raise again for the third round.
      if (t == 0) m0_if.req = 1'b0;
      if (t == 1) m0_if.req = 1'b1;
    end
    clear_inputs();
  endtask

  task automatic test_alternate();
    int m0_grants = 0;
    int m1_grants = 0;
    do_reset();
    m0_if.req = 1'b1; m0_if.addr = 32'hA0; m0_if.wdata = 32'h1111;
    m1_if.req = 1'b1; m1_if.addr = 32'hB0; m1_if.wdata = 32'h2222;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (slv_if.sel !== k[0] || slv_if.addr !== (k[0] ? 32'hB0 : 32'hA0) ||
          slv_if.wdata !== (k[0] ? 32'h2222 : 32'h1111)) begin
        fails++;
        $display("FAIL alt_grant[%0d]: sel=%b addr=%h wdata=%h required %b", k,
                 slv_if.sel, slv_if.addr, slv_if.wdata, k[0]);
      end
      tests++;
      if (ack_m0 !== 1'b0 || ack_m1 !== 1'b0) begin
        fails++;
        $display("FAIL alt_early_ack[%0d]: ack0=%b ack1=%b required 0 0", k, ack_m0, ack_m1);
      end
      tick();
      tests++;
      if (slv_if.req !== 1'b1 || slv_if.sel !== k[0]) begin
        fails++;
        $display("FAIL alt_hold[%0d]: req=%b sel=%b required 1 %b", k,
                 slv_if.req, slv_if.sel, k[0]);
      end
      slv_ack = 1'b1;
      #1;
      if (ack_m0) m0_grants++;
      if (ack_m1) m1_grants++;
      tests++;
      if (ack_m0 !== ~k[0] || ack_m1 !== k[0]) begin
        fails++;
        $display("FAIL alt_ack[%0d]: ack0=%b ack1=%b required %b %b", k,
                 ack_m0, ack_m1, ~k[0], k[0]);
      end
      tick();
      slv_ack = 1'b0;
    end
    tests++;
    if (m0_grants != 2 || m1_grants != 2) begin
      fails++;
      $display("FAIL alt_count: m0=%0d m1=%0d required 2 2", m0_grants, m1_grants);
    end
    clear_inputs();
  endtask

  task automatic test_hold();
    m1_if.req = 1'b1; m1_if.addr = 32'h20; m1_if.wdata = 32'h55;
    tick();
    tests++;
    if (slv_if.req !== 1'b1 || slv_if.sel !== 1'b1 || slv_if.addr !== 32'h20) begin
      fails++;
      $display("FAIL hold_grant: req=%b sel=%b addr=%h required 1 1 20",
               slv_if.req, slv_if.sel, slv_if.addr);
    end
    m1_if.addr = 32'h30; m1_if.wdata = 32'h66; m1_if.req = 1'b0;
    tick();
    tests++;
    if (slv_if.req !== 1'b1 || slv_if.addr !== 32'h20 || slv_if.wdata !== 32'h55) begin
      fails++;
      $display("FAIL hold_latched: req=%b addr=%h wdata=%h required 1 20 55",
               slv_if.req, slv_if.addr, slv_if.wdata);
    end
    slv_ack = 1'b1;
    #1;
    tests++;
    if (ack_m1 !== 1'b1 || ack_m0 !== 1'b0) begin
      fails++;
      $display("FAIL hold_ack: ack0=%b ack1=%b required 0 1", ack_m0, ack_m1);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    m0_if.req = 1'b1; m0_if.addr = 32'h40; m0_if.wdata = 32'h77;
    tick();
    tests++;
    if (slv_if.req !== 1'b1 || slv_if.addr !== 32'h40) begin
      fails++;
      $display("FAIL rstbusy_grant: req=%b addr=%h required 1 40", slv_if.req, slv_if.addr);
    end
    #2;
    rst_n = 1'b0;
    m0_if.req = 1'b0;
    #1;
    tests++;
    if ({slv_if.req, slv_if.sel, ack_m0, ack_m1} !== 4'b0000 || slv_if.addr !== 32'h0 ||
        slv_if.wdata !== 32'h0) begin
      fails++;
      $display("FAIL rstbusy_async: req=%b addr=%h wdata=%h required 0 0 0",
               slv_if.req, slv_if.addr, slv_if.wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    slv_ack = 1'b1;
    #1;
    tests++;
    if (ack_m0 !== 1'b0 || ack_m1 !== 1'b0 || slv_if.req !== 1'b0) begin
      fails++;
      $display("FAIL rstbusy_noack: ack0=%b ack1=%b req=%b required 0 0 0",
               ack_m0, ack_m1, slv_if.req);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_ack_idle();
    slv_ack = 1'b1;
    #1;
    tests++;
    if (ack_m0 !== 1'b0 || ack_m1 !== 1'b0) begin
      fails++;
      $display("FAIL idle_ack: ack0=%b ack1=%b required 0 0", ack_m0, ack_m1);
    end
    tick();
    tests++;
    if (slv_if.req !== 1'b0 || ack_m0 !== 1'b0 || ack_m1 !== 1'b0) begin
      fails++;
      $display("FAIL idle_stay: req=%b ack0=%b ack1=%b required 0 0 0",
               slv_if.req, ack_m0, ack_m1);
    end
    slv_ack = 1'b0;
    m0_if.req = 1'b1; m0_if.addr = 32'h50; m0_if.wdata = 32'h99;
    tick();
    tests++;
    if (slv_if.req !== 1'b1 || slv_if.sel !== 1'b0 || slv_if.addr !== 32'h50) begin
      fails++;
      $display("FAIL idle_then_grant: req=%b sel=%b addr=%h required 1 0 50",
               slv_if.req, slv_if.sel, slv_if.addr);
    end
    clear_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_contention();
    test_alternate();
    test_hold();
    test_reset_busy();
    test_ack_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1);
  end

endmodule

// File: doc/wr_req_arbiter.md
WR_REQ_ARBITER -- requirements
Module: wr_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of wr_req_if.
REQ-002 Parameter DATA_W, default 32, write-data width of wr_req_if.
REQ-003 Parameter SEL_W, default 1, width of the sel field; this is the master index width.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 i_wr_req_m0  wr_req_if.in  sel/addr/wdata/req  request from master 0's switch for this slave port.
REQ-007 i_wr_req_m1  wr_req_if.in  sel/addr/wdata/req  request from master 1's switch for this slave port.
REQ-008 o_wr_req_slv  wr_req_if.out  sel/addr/wdata/req  arbitrated request to the slave.
REQ-009 i_slv_ack  in  1  slave accepted the current write.
REQ-010 o_ack_m0, o_ack_m1  out  1 each  completion returned to the owning master.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY; a 1-bit owner register and a 1-bit priority pointer prio.
REQ-012 In IDLE with exactly one reqN=1, the FSM SHALL grant master N, go to BUSY next edge.
REQ-013 In IDLE with both req=1, the FSM SHALL grant the master equal to prio.
REQ-014 On grant, the block SHALL register addr, wdata of the granted master, set owner=N.
REQ-015 In BUSY, o_wr_req_slv.req SHALL be 1, addr/wdata SHALL be the latched values, and sel SHALL equal owner.
REQ-016 Latency SHALL be exactly 1 cycle from req sampled in IDLE to o_wr_req_slv.req=1.
REQ-017 In BUSY with i_slv_ack=1, o_ack_<owner> SHALL be 1 in the same cycle (combinational), the other ack 0.
REQ-018 On that edge the FSM SHALL return to IDLE and set prio = ~owner.
REQ-019 Each transaction SHALL take at least 2 cycles per grant; IDLE lasts at least one cycle between grants.
REQ-020 i_slv_ack in IDLE SHALL be ignored; no o_ack pulse.
REQ-021 Requester inputs SHALL be ignored in BUSY; deassertion of a granted req before ack does not abort; latched data SHALL not change.
REQ-022 Outside BUSY, o_wr_req_slv fields SHALL all be 0.
REQ-023 Masters SHALL hold req and data stable until their ack; a master whose req stays high after ack SHALL be re-eligible in the next IDLE.
REQ-024 Under continuous contention, grants SHALL alternate m0, m1, m0, ...; no master waits more than one other transaction.

Reset
REQ-025 While i_rst_n=0, state=IDLE, owner=0, prio=0 (master 0 preferred), latched addr/wdata=0.
REQ-026 While i_rst_n=0, all o_wr_req_slv fields and o_ack_m0/o_ack_m1 SHALL be 0, immediately, without a clock edge.
REQ-027 Reset asserted in BUSY SHALL drop the transaction silently; no ack is generated after release.
REQ-028 The first grant after reset release SHALL occur no earlier than the second rising edge after deassertion.

Structure
REQ-029 ADDR_W/DATA_W defaults, master-index constants M0=0/M1=1, and the state enum SHALL live in shared package xbar_pkg.
REQ-030 The priority and grant logic SHALL be sub-module rr_arb2 (inputs req[1:0], prio; output grant index, grant_valid).
REQ-031 The wr_req_if interface SHALL be reused unchanged; ack signals are discrete ports.

Verification
REQ-032 Scenario: after reset, m0 req, addr=0x10, wdata=0xAA -> next cycle slv req=1, addr=0x10, wdata=0xAA, sel=0; ack on cycle 3 -> o_ack_m0=1 same cycle, IDLE next.
REQ-033 Scenario: both request simultaneously after reset -> m0 is served first, then m1 with sel=1; the next simultaneous pair is served m0 first again.
REQ-034 Scenario: both hold req for 4 transactions with ack every 2nd BUSY cycle -> grant order m0, m1, m0, m1; no ack is misrouted.
REQ-035 Scenario: m1 granted with addr=0x20, then changes addr to 0x30 and drops req before ack -> slave still sees 0x20; o_ack_m1 pulses on ack.
REQ-036 Scenario: i_rst_n low mid-BUSY -> outputs 0 asynchronously; i_slv_ack pulse after release gives no o_ack.
REQ-037 Scenario: i_slv_ack=1 in IDLE with no req -> no ack output and state stays IDLE.
